fcr_host: RTL and testbench
===========================

FCR_HOST -- requirements
Module: fcr_host

Interface
REQ-001 SHALL have parameter TMO_CYCLES, default 16'd4096, the cycles allowed from command accept to response read before timeout.
REQ-002 SHALL have port clk, input, 1: the single module clock.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 1: a transaction request, sampled only when req_ready=1.
REQ-005 SHALL have port req_cmd, input, 32: the command word (opcode [31:16], argument [15:0]).
REQ-006 SHALL have port req_ready, output, 1: block idle and able to accept req.
REQ-007 SHALL have port done, output, 1: one-cycle pulse ending a transaction.
REQ-008 SHALL have port done_rsp, output, 32: the response word, valid while done=1.
REQ-009 SHALL have port done_err, output, 1: responder-flagged error, i.e. response bit 31 set.
REQ-010 SHALL have port done_mismatch, output, 1: response [30:16] differs from command [30:16].
REQ-011 SHALL have port done_tmo, output, 1: the transaction timed out.
REQ-012 SHALL have ports cmd_wrdata (output, 32) and cmd_wrreq (output, 1): the command FIFO write side.
REQ-013 SHALL have port cmd_waitreq, input, 1: command FIFO full, no write accepted.
REQ-014 SHALL have ports rsp_rddata (input, 32) and rsp_rdreq (output, 1): the response FIFO read side.
REQ-015 SHALL have port rsp_waitreq, input, 1: response FIFO empty; low means a word is available.
REQ-016 SHALL have port flush_cnt, output, 8: a saturating count of discarded stale responses.

Function
REQ-017 SHALL implement a state machine with states S_IDLE, S_FLUSH, S_WR_CMD, S_WAIT_RSP, S_RD_RSP and S_DONE.
REQ-018 SHALL drive req_ready=1 only in S_IDLE when rsp_waitreq=1.
REQ-019 In S_IDLE, if rsp_waitreq=0, SHALL go to S_FLUSH; a flush takes priority over a simultaneous req.
REQ-020 In S_IDLE, if req=1 and rsp_waitreq=1, SHALL latch req_cmd, clear the timeout counter and go to S_WR_CMD.
REQ-021 S_FLUSH SHALL assert rsp_rdreq for one cycle, increment flush_cnt saturating at 8'hFF, and return to S_IDLE.
REQ-022 SHALL drive cmd_wrdata from the latched command at all times and assert cmd_wrreq = (S_WR_CMD && !cmd_waitreq), combinationally.
REQ-023 S_WR_CMD SHALL go to S_WAIT_RSP in the cycle cmd_wrreq=1.
REQ-024 S_WAIT_RSP SHALL go to S_RD_RSP when rsp_waitreq=0.
REQ-025 S_RD_RSP SHALL assert rsp_rdreq for exactly one cycle, capture rsp_rddata in that cycle, and go to S_DONE.
REQ-026 The 16-bit timeout counter SHALL increment every cycle in S_WR_CMD and S_WAIT_RSP.
REQ-027 When the counter equals TMO_CYCLES-1, SHALL go to S_DONE with done_tmo=1 and done_rsp=32'h0; a timeout outranks a simultaneous cmd_wrreq or rsp availability in that cycle.
REQ-028 S_DONE SHALL assert done for one cycle with done_rsp, done_err and done_mismatch valid, then return to S_IDLE.
REQ-029 SHALL compute done_err and done_mismatch from the captured response only, forcing both to 0 when done_tmo=1.
REQ-030 A response arriving after a timeout SHALL be discarded by S_FLUSH before the next command is accepted.
REQ-031 Best-case latency SHALL be 4 cycles from the req-accept edge to done when both FIFOs are immediately ready.
REQ-032 Only one transaction SHALL be outstanding at a time.

Reset
REQ-033 With rst=1 at a clk edge, SHALL enter S_IDLE and clear the timeout counter, flush_cnt, the latched command and the captured response.
REQ-034 During and after reset, SHALL hold cmd_wrreq, rsp_rdreq, done, done_err, done_mismatch and done_tmo at 0, and done_rsp and cmd_wrdata at 32'h0.
REQ-035 A reset mid-transaction SHALL abort the transaction without a done pulse; any response later delivered by the responder SHALL be flushed.

Structure
REQ-036 Command opcode constants and the error-bit position (31) SHALL live in the shared command-definitions package used by the FPGA-side command controller.
REQ-037 The state encoding SHALL be local to the module.
REQ-038 No sub-module is required; the timeout counter may be factored out as fcr_tmo.

Verification
REQ-039 req_cmd=32'h0005_0001, responder echoes 32'h0005_0001 immediately -> done at cycle 4, done_rsp=32'h0005_0001, all flags 0.
REQ-040 cmd_waitreq held high 10 cycles -> cmd_wrreq stays 0, then a single write; done_tmo=0.
REQ-041 Responder returns 32'h8005_0001 -> done_err=1, done_mismatch=0.
REQ-042 Responder returns 32'h0006_0000 for command 32'h0005_0000 -> done_mismatch=1.
REQ-043 TMO_CYCLES=16, no response -> done_tmo=1 with done_rsp=0; a late response then arrives -> flush_cnt=1 and req_ready stays low until the flush completes.
REQ-044 rst asserted while in S_WAIT_RSP -> no done pulse; all outputs return to 0 the next cycle.

Source files
------------

// File: rtl/fcr_host_pkg.sv
// Shared command definitions for the FCR host/controller pair: opcode
// constants, the layout of a command word and the echo-check helper.
package fcr_host_pkg;

    localparam int CMD_W    = 32;
    localparam int ERR_BIT  = 31;   // responder sets this bit to flag an error
    localparam int ECHO_MSB = 30;   // response echoes the opcode in [30:16]
    localparam int ECHO_LSB = 16;

    localparam logic [15:0] OP_NOP    = 16'h0000;
    localparam logic [15:0] OP_RESET  = 16'h0001;
    localparam logic [15:0] OP_STATUS = 16'h0002;
    localparam logic [15:0] OP_RD_REG = 16'h0005;
    localparam logic [15:0] OP_WR_REG = 16'h0006;

    typedef struct packed {
        logic [15:0] opcode;
        logic [15:0] arg;
    } fcr_cmd_t;

    // True when the echoed opcode field of a response does not match the command.
    function automatic logic echo_mismatch(input logic [CMD_W-1:0] cmd,
                                           input logic [CMD_W-1:0] rsp);
        return cmd[ECHO_MSB:ECHO_LSB] != rsp[ECHO_MSB:ECHO_LSB];
    endfunction

endpackage

// File: rtl/fcr_tmo.sv
// Transaction timeout counter: cleared when a command is accepted, counts
// while the host is writing the command or waiting for the response.
module fcr_tmo #(
    parameter logic [15:0] TMO_CYCLES = 16'd4096
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [15:0] r_cnt;

    // Count enabled cycles since the last clear.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_expired = i_en && (r_cnt == TMO_CYCLES - 16'd1);

endmodule

// File: rtl/fcr_host.sv
// FCR host: issues one command word into the command FIFO, waits for the
// matching response word, checks it, and reports the result with a one-cycle
// done pulse. Stale responses found while idle are drained and counted.
module fcr_host
    import fcr_host_pkg::*;
#(
    parameter logic [15:0] TMO_CYCLES = 16'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] req_cmd,
    output logic        req_ready,
    output logic        done,
    output logic [31:0] done_rsp,
    output logic        done_err,
    output logic        done_mismatch,
    output logic        done_tmo,
    output logic [31:0] cmd_wrdata,
    output logic        cmd_wrreq,
    input  logic        cmd_waitreq,
    input  logic [31:0] rsp_rddata,
    output logic        rsp_rdreq,
    input  logic        rsp_waitreq,
    output logic [7:0]  flush_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_WR_CMD,
        S_WAIT_RSP,
        S_RD_RSP,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    fcr_cmd_t    r_cmd;
    logic [31:0] r_rsp;
    logic        r_tmo;
    logic [7:0]  r_flush_cnt;

    logic        w_accept;
    logic        w_wrreq;
    logic        w_tmo_en;
    logic        w_tmo_hit;

    // A stale response (rsp_waitreq low) blocks acceptance so it gets flushed first.
    assign w_accept = (r_state == S_IDLE) && rsp_waitreq && req;
    assign w_wrreq  = (r_state == S_WR_CMD) && !cmd_waitreq;
    assign w_tmo_en = (r_state == S_WR_CMD) || (r_state == S_WAIT_RSP);

    fcr_tmo #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_accept),
        .i_en      (w_tmo_en),
        .o_expired (w_tmo_hit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; timeout outranks a write or response in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!rsp_waitreq) begin
                    w_next = S_FLUSH;
                end else if (req) begin
                    w_next = S_WR_CMD;
                end
            end
            S_FLUSH:    w_next = S_IDLE;
            S_WR_CMD: begin
                if (w_tmo_hit) begin
                    w_next = S_DONE;
                end else if (w_wrreq) begin
                    w_next = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (w_tmo_hit) begin
                    w_next = S_DONE;
                end else if (!rsp_waitreq) begin
                    w_next = S_RD_RSP;
                end
            end
            S_RD_RSP:   w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Output decode; everything is forced low while rst is held.
    // NOTE: every output gets a default before the case, so no latch is inferred.
    always_comb begin
        req_ready     = 1'b0;
        done          = 1'b0;
        done_rsp      = '0;
        done_err      = 1'b0;
        done_mismatch = 1'b0;
        done_tmo      = 1'b0;
        cmd_wrreq     = 1'b0;
        cmd_wrdata    = '0;
        rsp_rdreq     = 1'b0;
        if (!rst) begin
            cmd_wrdata = r_cmd;
            case (r_state)
                S_IDLE:   req_ready = rsp_waitreq;
                S_FLUSH:  rsp_rdreq = 1'b1;
                S_WR_CMD: cmd_wrreq = w_wrreq;
                S_RD_RSP: rsp_rdreq = 1'b1;
                S_DONE: begin
                    done     = 1'b1;
                    done_tmo = r_tmo;
                    if (!r_tmo) begin
                        done_rsp      = r_rsp;
                        done_err      = r_rsp[ERR_BIT];
                        done_mismatch = echo_mismatch(r_cmd, r_rsp);
                    end
                end
                default: ;
            endcase
        end
    end

    // Command/response capture, timeout flag and the flush counter.
    // NOTE: the data registers are reset too, so cmd_wrdata and done_rsp read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd       <= '0;
            r_rsp       <= '0;
            r_tmo       <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_cmd <= req_cmd;
                r_tmo <= 1'b0;
            end
            if (r_state == S_RD_RSP) begin
                r_rsp <= rsp_rddata;
            end
            if (w_tmo_hit) begin
                r_tmo <= 1'b1;
                r_rsp <= '0;
            end
            if (r_state == S_FLUSH && r_flush_cnt != 8'hFF) begin
                r_flush_cnt <= r_flush_cnt + 8'd1;
            end
        end
    end

    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_fcr_host.sv
// Bench for fcr_host: table of transactions against a behavioural responder,
// expected results queued at issue and compared when done pulses, plus
// hand-written sequences for late-response flush and mid-transaction reset.
module tb_fcr_host;

    localparam logic [15:0] TMO = 16'd16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] req_cmd = '0;
    logic        cmd_waitreq = 1'b0;
    logic        rsp_waitreq = 1'b1;
    logic [31:0] rsp_rddata = '0;
    logic        req_ready, done, done_err, done_mismatch, done_tmo;
    logic        cmd_wrreq, rsp_rdreq;
    logic [31:0] done_rsp, cmd_wrdata;
    logic [7:0]  flush_cnt;

    fcr_host #(.TMO_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_cmd       (req_cmd),
        .req_ready     (req_ready),
        .done          (done),
        .done_rsp      (done_rsp),
        .done_err      (done_err),
        .done_mismatch (done_mismatch),
        .done_tmo      (done_tmo),
        .cmd_wrdata    (cmd_wrdata),
        .cmd_wrreq     (cmd_wrreq),
        .cmd_waitreq   (cmd_waitreq),
        .rsp_rddata    (rsp_rddata),
        .rsp_rdreq     (rsp_rdreq),
        .rsp_waitreq   (rsp_waitreq),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] cmd;
        logic [31:0] rsp;     // word the responder returns
        int          dly;     // cycles after the write before it appears
        int          hold;    // cycles cmd_waitreq stays high after accept
        logic [31:0] e_rsp;
        logic        e_err;
        logic        e_mis;
        logic        e_tmo;
        int          e_lat;   // accept edge to done-sampling edge
    } vec_t;

    typedef struct {
        logic [31:0] rsp;
        logic        err;
        logic        mis;
        logic        tmo;
        int          lat;
    } exp_t;

    vec_t        vecs[7];
    exp_t        sb_q[$];
    exp_t        e;
    logic [31:0] rsp_q[$];
    logic [31:0] cur_cmd = '0;
    logic [31:0] cfg_rsp = '0;
    int          cfg_dly = 0;
    int          pend_cnt = -1;
    logic [31:0] pend_word = '0;
    int          accept_cyc = 0;
    int          n_wr = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Responder: command FIFO write triggers a (possibly delayed) response word.
    initial begin
        bit rd, wr;
        forever begin
            @(negedge clk);
            rd = rsp_rdreq;
            wr = cmd_wrreq;
            @(posedge clk);
            #1;
            if (rd && rsp_q.size() > 0) void'(rsp_q.pop_front());
            if (wr) begin
                pend_word = cfg_rsp;
                pend_cnt  = cfg_dly;
            end
            if (pend_cnt == 0) begin
                rsp_q.push_back(pend_word);
                pend_cnt = -1;
            end else if (pend_cnt > 0) begin
                pend_cnt--;
            end
            rsp_waitreq = (rsp_q.size() == 0);
            rsp_rddata  = (rsp_q.size() > 0) ? rsp_q[0] : 32'h0;
        end
    end

    // Monitor: command writes and done pulses against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (cmd_wrreq) begin
                n_wr++;
                check("cmd_wrdata", cmd_wrdata, cur_cmd);
            end
            if (cmd_waitreq) check("wrreq_while_full", {31'b0, cmd_wrreq}, 32'h0);
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'h1, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_rsp", done_rsp, e.rsp);
                    check("done_err", {31'b0, done_err}, {31'b0, e.err});
                    check("done_mismatch", {31'b0, done_mismatch}, {31'b0, e.mis});
                    check("done_tmo", {31'b0, done_tmo}, {31'b0, e.tmo});
                    if (e.lat > 0) check("latency", cyc + 1 - accept_cyc, e.lat);
                end
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (!req_ready) check("req_ready_wait", {31'b0, req_ready}, 32'h1);
    endtask

    task automatic run_vec(input vec_t v);
        int wr_base;
        cfg_rsp = v.rsp;
        cfg_dly = v.dly;
        wait_ready();
        cur_cmd     = v.cmd;
        wr_base     = n_wr;
        req         = 1'b1;
        req_cmd     = v.cmd;
        cmd_waitreq = (v.hold > 0);
        sb_q.push_back('{v.e_rsp, v.e_err, v.e_mis, v.e_tmo, v.e_lat});
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        req = 1'b0;
        check("req_ready_busy", {31'b0, req_ready}, 32'h0);
        repeat (v.hold) @(posedge clk);
        #1;
        cmd_waitreq = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (sb_q.size() == 0) break;
        end
        if (sb_q.size() != 0) begin
            check("done_wait", 32'h0, 32'h1);
            sb_q.delete();
        end
        check("write_count", n_wr - wr_base, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0005_0001, 32'h0005_0001,  0,  0, 32'h0005_0001, 1'b0, 1'b0, 1'b0,  4};
        vecs[1] = '{32'h0005_0002, 32'h0005_0002,  0, 10, 32'h0005_0002, 1'b0, 1'b0, 1'b0, 14};
        vecs[2] = '{32'h0005_0001, 32'h8005_0001,  0,  0, 32'h8005_0001, 1'b1, 1'b0, 1'b0,  4};
        vecs[3] = '{32'h0005_0000, 32'h0006_0000,  0,  0, 32'h0006_0000, 1'b0, 1'b1, 1'b0,  4};
        vecs[4] = '{32'h1234_ABCD, 32'h1234_ABCD,  5,  0, 32'h1234_ABCD, 1'b0, 1'b0, 1'b0,  9};
        vecs[5] = '{32'h0003_0000, 32'h8004_0000,  2,  0, 32'h8004_0000, 1'b1, 1'b1, 1'b0,  6};
        vecs[6] = '{32'h0005_0007, 32'h8009_0000, 30,  0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 17};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {25'b0, req_ready, done, done_err, done_mismatch, done_tmo, cmd_wrreq, rsp_rdreq}, 32'h0);
        check("rst_done_rsp", done_rsp, 32'h0);
        check("rst_cmd_wrdata", cmd_wrdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", {31'b0, req_ready}, 32'h1);
        check("idle_flush_cnt", {24'b0, flush_cnt}, 32'h0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Late response after the timeout: flushed before new work, req ignored meanwhile.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!rsp_waitreq) break;
        end
        check("late_rsp_seen", {31'b0, rsp_waitreq}, 32'h0);
        check("late_req_ready", {31'b0, req_ready}, 32'h0);
        check("late_flush_cnt0", {24'b0, flush_cnt}, 32'h0);
        req = 1'b1;
        req_cmd = 32'h0001_0000;
        @(negedge clk);
        check("flush_rdreq", {31'b0, rsp_rdreq}, 32'h1);
        check("flush_req_ready", {31'b0, req_ready}, 32'h0);
        req = 1'b0;
        @(negedge clk);
        check("flush_cnt1", {24'b0, flush_cnt}, 32'h1);
        check("post_flush_ready", {31'b0, req_ready}, 32'h1);
        check("post_flush_wrreq", {31'b0, cmd_wrreq}, 32'h0);

        // Reset while waiting for a response: no done, later response flushed.
        cfg_rsp = 32'h0005_00AA;
        cfg_dly = 30;
        wait_ready();
        cur_cmd = 32'h0005_00AA;
        req     = 1'b1;
        req_cmd = 32'h0005_00AA;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ctrl", {25'b0, req_ready, done, done_err, done_mismatch, done_tmo, cmd_wrreq, rsp_rdreq}, 32'h0);
        check("midrst_data", done_rsp | cmd_wrdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_flush_cnt", {24'b0, flush_cnt}, 32'h0);
        check("midrst_idle", {31'b0, req_ready}, 32'h1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (flush_cnt == 8'd1) break;
        end
        check("midrst_flushed", {24'b0, flush_cnt}, 32'h1);

        // Recovery after reset and flush.
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
